// File: rtl/ra_march_sdr_32x32_if.sv
// rtl/ra_march_sdr_32x32_if.sv - 2R1W register-array port bundle driven by the March C- sequencer
interface ra_march_sdr_32x32_if;
    logic        rd_enb_0;
    logic        rd_enb_1;
    logic [0:4]  rd_adr_0;
    logic [0:4]  rd_adr_1;
    logic [0:31] rd_dat_0;
    logic [0:31] rd_dat_1;
    logic        wr_enb_0;
    logic [0:4]  wr_adr_0;
    logic [0:31] wr_dat_0;

    modport master (
        output rd_enb_0, rd_enb_1, rd_adr_0, rd_adr_1, wr_enb_0, wr_adr_0, wr_dat_0,
        input  rd_dat_0, rd_dat_1
    );

    modport slave (
        input  rd_enb_0, rd_enb_1, rd_adr_0, rd_adr_1, wr_enb_0, wr_adr_0, wr_dat_0,
        output rd_dat_0, rd_dat_1
    );
endinterface

// File: rtl/ra_march_sdr_32x32.sv
// rtl/ra_march_sdr_32x32.sv - March C- sequencer and dual-port checker for the 2R1W 32x32 array
module ra_march_sdr_32x32 #(
    parameter int RD_LAT       = 1,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:31] bg,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [0:4]  fail_adr,
    output logic [0:2]  fail_elem,
    output logic        fail_port,
    output logic [0:7]  fail_cnt,
    ra_march_sdr_32x32_if.master arr
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      state;
    logic [2:0]  elem;
    logic [4:0]  adr;
    logic        ph;
    logic        last_iss;
    logic [0:31] bg_q;
    logic [0:31] rd_exp;
    logic [2:0]  rd_elem;
    logic [1:0]  drain_cnt;

    logic        p_vld  [RD_LAT];
    logic [0:31] p_exp  [RD_LAT];
    logic [4:0]  p_adr  [RD_LAT];
    logic [2:0]  p_elem [RD_LAT];

    logic        accept, issue, is_rd, up, mm0, mm1, stop_now;
    logic [2:0]  src_e, nxt_e;
    logic [4:0]  src_a, nxt_a;
    logic        src_p, nxt_p;
    logic [0:31] src_bg, rd_word, wr_word;
    logic [8:0]  cnt_sum;

    // Counters name the next op to issue; on an accepted start the source is forced to E0/adr 0.
    always_comb begin
        accept  = start && (state == S_IDLE || state == S_DONE);
        src_e   = accept ? 3'd0 : elem;
        src_a   = accept ? 5'd0 : adr;
        src_p   = accept ? 1'b0 : ph;
        src_bg  = accept ? bg : bg_q;
        is_rd   = (src_e == 3'd5) || (src_e != 3'd0 && !src_p);
        rd_word = (src_e == 3'd2 || src_e == 3'd4) ? ~src_bg : src_bg;
        wr_word = (src_e == 3'd1 || src_e == 3'd3) ? ~src_bg : src_bg;
        up      = !(src_e == 3'd3 || src_e == 3'd4);
        nxt_e   = src_e;
        nxt_a   = src_a;
        nxt_p   = 1'b0;
        if (src_e >= 3'd1 && src_e <= 3'd4 && !src_p) begin
            nxt_p = 1'b1;
        end else if (src_a == (up ? 5'd31 : 5'd0)) begin
            nxt_e = src_e + 3'd1;
            nxt_a = (nxt_e == 3'd3 || nxt_e == 3'd4) ? 5'd31 : 5'd0;
        end else begin
            nxt_a = up ? src_a + 5'd1 : src_a - 5'd1;
        end
        mm0      = p_vld[RD_LAT-1] && (arr.rd_dat_0 != p_exp[RD_LAT-1]);
        mm1      = p_vld[RD_LAT-1] && (arr.rd_dat_1 != p_exp[RD_LAT-1]);
        cnt_sum  = {1'b0, fail_cnt} + {8'd0, mm0} + {8'd0, mm1};
        stop_now = STOP_ON_FAIL && (mm0 || mm1) && !fail;
        issue    = accept || (state == S_RUN && !last_iss && !stop_now);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            elem      <= 3'd0;
            adr       <= 5'd0;
            ph        <= 1'b0;
            last_iss  <= 1'b0;
            bg_q      <= '0;
            rd_exp    <= '0;
            rd_elem   <= 3'd0;
            drain_cnt <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_adr  <= '0;
            fail_elem <= '0;
            fail_port <= 1'b0;
            fail_cnt  <= '0;
            arr.rd_enb_0 <= 1'b0;
            arr.rd_enb_1 <= 1'b0;
            arr.rd_adr_0 <= '0;
            arr.rd_adr_1 <= '0;
            arr.wr_enb_0 <= 1'b0;
            arr.wr_adr_0 <= '0;
            arr.wr_dat_0 <= '0;
            for (int i = 0; i < RD_LAT; i++) p_vld[i] <= 1'b0;
        end else begin
            p_vld[0]  <= arr.rd_enb_0;
            p_exp[0]  <= rd_exp;
            p_adr[0]  <= arr.rd_adr_0;
            p_elem[0] <= rd_elem;
            for (int i = 1; i < RD_LAT; i++) begin
                p_vld[i]  <= p_vld[i-1];
                p_exp[i]  <= p_exp[i-1];
                p_adr[i]  <= p_adr[i-1];
                p_elem[i] <= p_elem[i-1];
            end

            if (mm0 || mm1) begin
                fail     <= 1'b1;
                fail_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
                if (!fail) begin
                    fail_adr  <= p_adr[RD_LAT-1];
                    fail_elem <= p_elem[RD_LAT-1];
                    fail_port <= !mm0;
                end
            end

            if (issue) begin
                arr.rd_enb_0 <= is_rd;
                arr.rd_enb_1 <= is_rd;
                arr.rd_adr_0 <= is_rd ? src_a : 5'd0;
                arr.rd_adr_1 <= is_rd ? src_a : 5'd0;
                arr.wr_enb_0 <= !is_rd;
                arr.wr_adr_0 <= is_rd ? 5'd0 : src_a;
                arr.wr_dat_0 <= is_rd ? '0 : wr_word;
                rd_exp       <= rd_word;
                rd_elem      <= src_e;
                elem         <= nxt_e;
                adr          <= nxt_a;
                ph           <= nxt_p;
                last_iss     <= (src_e == 3'd5) && (src_a == 5'd31);
            end else begin
                arr.rd_enb_0 <= 1'b0;
                arr.rd_enb_1 <= 1'b0;
                arr.rd_adr_0 <= '0;
                arr.rd_adr_1 <= '0;
                arr.wr_enb_0 <= 1'b0;
                arr.wr_adr_0 <= '0;
                arr.wr_dat_0 <= '0;
            end

            unique case (state)
                S_IDLE, S_DONE: if (accept) begin
                    state     <= S_RUN;
                    bg_q      <= bg;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    fail      <= 1'b0;
                    fail_adr  <= '0;
                    fail_elem <= '0;
                    fail_port <= 1'b0;
                    fail_cnt  <= '0;
                end
                S_RUN: if (last_iss || stop_now) begin
                    state     <= S_DRAIN;
                    drain_cnt <= 2'(RD_LAT - 1);
                end
                S_DRAIN: begin
                    if (drain_cnt == 2'd0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !(fail || mm0 || mm1);
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ra_march_sdr_32x32.sv
// tb/tb_ra_march_sdr_32x32.sv - bench for the March C- sequencer with behavioural array and march model
module tb_ra_march_sdr_32x32;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic reset;
    logic [NI-1:0]       start_v, busy_v, done_v, pass_v, fail_v, fport_v;
    logic [NI-1:0]       rden0_v, rden1_v, wren_v, flt_v;
    logic [NI-1:0][31:0] bg_v, wrdat_v;
    logic [NI-1:0][4:0]  rdadr0_v, rdadr1_v, wradr_v, fadr_v;
    logic [NI-1:0][2:0]  felem_v;
    logic [NI-1:0][7:0]  fcnt_v;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // instance 0: RD_LAT=1; instance 1: RD_LAT=1 with stop-on-fail; instance 2: RD_LAT=2
    for (genvar g = 0; g < NI; g++) begin : gi
        ra_march_sdr_32x32_if bus();
        logic [31:0] mem [32];
        logic [31:0] d0 [3];
        logic [31:0] d1 [3];
        logic [31:0] rv0, rv1;

        assign rv1 = mem[bus.rd_adr_1];
        assign rv0 = mem[bus.rd_adr_0] & ~((flt_v[g] && bus.rd_adr_0 == 5'd7) ? 32'h0400_0000 : 32'h0);

        always @(posedge clk) begin
            if (bus.wr_enb_0) mem[bus.wr_adr_0] <= bus.wr_dat_0;
            d0[0] <= rv0;   d1[0] <= rv1;
            d0[1] <= d0[0]; d1[1] <= d1[0];
            d0[2] <= d0[1]; d1[2] <= d1[1];
        end
        assign bus.rd_dat_0 = d0[(g == 2) ? 1 : 0];
        assign bus.rd_dat_1 = d1[(g == 2) ? 1 : 0];

        ra_march_sdr_32x32 #(.RD_LAT((g == 2) ? 2 : 1), .STOP_ON_FAIL(g == 1)) dut (
            .clk(clk), .reset(reset), .start(start_v[g]), .bg(bg_v[g]),
            .busy(busy_v[g]), .done(done_v[g]), .pass(pass_v[g]), .fail(fail_v[g]),
            .fail_adr(fadr_v[g]), .fail_elem(felem_v[g]), .fail_port(fport_v[g]),
            .fail_cnt(fcnt_v[g]), .arr(bus)
        );

        assign rden0_v[g]  = bus.rd_enb_0;
        assign rden1_v[g]  = bus.rd_enb_1;
        assign rdadr0_v[g] = bus.rd_adr_0;
        assign rdadr1_v[g] = bus.rd_adr_1;
        assign wren_v[g]   = bus.wr_enb_0;
        assign wradr_v[g]  = bus.wr_adr_0;
        assign wrdat_v[g]  = bus.wr_dat_0;
    end

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [4:0]  adr;
        logic [31:0] dat;
    } op_t;

    typedef struct {
        int          g;
        logic [31:0] b;
        bit          flt;
        bit          mid;
        bit          ep;
        int          ecnt, eadr, eelem, eport, edone;
    } vec_t;

    op_t exp_q[$];
    int  exp_n;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // March C- as an op list; faulty reads replay the stuck-at bit against a plain memory array.
    task automatic build_model(input int lat, input bit stop, input logic [31:0] b, input bit flt,
                               output int done_at, output int cnt, output int fadr,
                               output int felem, output int fport);
        int          rpol [6] = '{-1, 0, 1, 0, 1, 0};
        int          wpol [6] = '{0, 1, 0, 1, 0, -1};
        bit          down [6] = '{0, 0, 0, 1, 1, 0};
        logic [31:0] memv [32];
        int          mism [$];
        int          first = -1;
        int          a;
        logic [31:0] ev, r0;
        exp_q.delete();
        cnt = 0; fadr = 0; felem = 0; fport = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 32; i++) begin
                a = down[e] ? 31 - i : i;
                if (rpol[e] >= 0) begin
                    ev = (rpol[e] == 1) ? ~b : b;
                    r0 = memv[a];
                    if (flt && a == 7) r0[26] = 1'b0;
                    mism.push_back(int'(r0 != ev) + int'(memv[a] != ev));
                    if (first < 0 && r0 != ev) begin
                        first = exp_q.size(); fadr = a; felem = e; fport = 0;
                    end else if (first < 0 && memv[a] != ev) begin
                        first = exp_q.size(); fadr = a; felem = e; fport = 1;
                    end
                    exp_q.push_back('{1'b1, 1'b0, 5'(a), ev});
                end
                if (wpol[e] >= 0) begin
                    ev = (wpol[e] == 1) ? ~b : b;
                    memv[a] = ev;
                    mism.push_back(0);
                    exp_q.push_back('{1'b0, 1'b1, 5'(a), ev});
                end
            end
        end
        exp_n = 320;
        if (stop && first >= 0 && first + 1 + lat < 320) exp_n = first + 1 + lat;
        for (int k = 0; k < exp_n; k++) cnt += mism[k];
        if (cnt > 255) cnt = 255;
        done_at = exp_n + 1 + lat;
    endtask

    task automatic do_run(input int g, input logic [31:0] b, input bit flt, input bit mid,
                          input int edone, input bit ep, input int ecnt, input int eadr,
                          input int eelem, input int eport, input int mdone);
        op_t e;
        int  badk = 0;
        int  obs_done = -1;
        bit  ok;
        @(negedge clk);
        bg_v[g] = b; flt_v[g] = flt; start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            e = (k <= exp_n) ? exp_q[k-1] : '0;
            ok = (rden0_v[g] == e.rd) && (rden1_v[g] == e.rd) && (wren_v[g] == e.wr) &&
                 (rdadr0_v[g] == (e.rd ? e.adr : 5'd0)) && (rdadr1_v[g] == (e.rd ? e.adr : 5'd0)) &&
                 (wradr_v[g] == (e.wr ? e.adr : 5'd0)) && (wrdat_v[g] == (e.wr ? e.dat : 32'd0)) &&
                 (busy_v[g] == (k < mdone)) && (done_v[g] == (k >= mdone));
            if (!ok && badk == 0) badk = k;
            if (done_v[g]) begin
                obs_done = k;
                break;
            end
            start_v[g] = (mid && k == 150);
            @(negedge clk);
        end
        start_v[g] = 1'b0;
        chk($sformatf("trace_g%0d_first_bad_cycle", g), badk, 0);
        chk($sformatf("done_cycle_g%0d", g), obs_done, edone);
        chk($sformatf("pass_g%0d", g), pass_v[g], ep);
        chk($sformatf("fail_g%0d", g), fail_v[g], !ep);
        chk($sformatf("fail_cnt_g%0d", g), fcnt_v[g], ecnt);
        chk($sformatf("fail_adr_g%0d", g), fadr_v[g], eadr);
        chk($sformatf("fail_elem_g%0d", g), felem_v[g], eelem);
        chk($sformatf("fail_port_g%0d", g), fport_v[g], eport);
        repeat (2) @(negedge clk);
        chk($sformatf("done_held_g%0d", g), done_v[g], 1);
    endtask

    vec_t tbl [6];
    int   md, mc, ma, me, mp;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 322};
        tbl[1] = '{0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2, 7, 2, 0, 322};
        tbl[2] = '{1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1, 7, 2, 0, 114};
        tbl[3] = '{1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 322};
        tbl[4] = '{2, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 323};
        tbl[5] = '{2, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 3, 7, 1, 0, 323};

        reset = 1'b1;
        start_v = '1;
        flt_v = '0;
        for (int g = 0; g < NI; g++) bg_v[g] = $urandom;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++)
            chk($sformatf("reset_outputs_g%0d", g),
                |{busy_v[g], done_v[g], pass_v[g], fail_v[g], fport_v[g], fadr_v[g], felem_v[g],
                  fcnt_v[g], rden0_v[g], rden1_v[g], rdadr0_v[g], rdadr1_v[g], wren_v[g],
                  wradr_v[g], wrdat_v[g]}, 0);
        start_v = '0;
        reset = 1'b0;
        @(negedge clk);
        chk("busy_after_start_with_reset", busy_v, 0);

        for (int i = 0; i < 6; i++) begin
            build_model((tbl[i].g == 2) ? 2 : 1, tbl[i].g == 1, tbl[i].b, tbl[i].flt, md, mc, ma, me, mp);
            do_run(tbl[i].g, tbl[i].b, tbl[i].flt, tbl[i].mid, tbl[i].edone, tbl[i].ep,
                   tbl[i].ecnt, tbl[i].eadr, tbl[i].eelem, tbl[i].eport, md);
        end

        @(negedge clk);
        bg_v[0] = 32'h0; flt_v[0] = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_reset_enables", {rden0_v[0], rden1_v[0], wren_v[0]}, 0);
        chk("midrun_reset_busy_done", {busy_v[0], done_v[0]}, 0);
        reset = 1'b0;
        build_model(1, 1'b0, 32'h0, 1'b0, md, mc, ma, me, mp);
        do_run(0, 32'h0, 1'b0, 1'b0, 322, 1'b1, 0, 0, 0, 0, md);

        for (int r = 0; r < 6; r++) begin
            int          g;
            logic [31:0] b;
            bit          flt;
            g   = $urandom_range(0, NI - 1);
            b   = $urandom;
            flt = 1'($urandom_range(0, 1));
            build_model((g == 2) ? 2 : 1, g == 1, b, flt, md, mc, ma, me, mp);
            do_run(g, b, flt, 1'($urandom_range(0, 1)), md, mc == 0, mc, ma, me, mp, md);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
